// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared definitions for the instruction-fetch slice: default reset PC,
//   PC increment, instruction width and the fetch-queue entry layout.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam int          INSTR_W          = 32;

  // One queued fetch: the byte address it was read from and the word itself.
  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue
//   Parameterised synchronous FIFO (circular buffer) holding fetched
//   instructions in order.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     push, din   write din at the tail (accepted when not full, or when a
//                 pop frees a slot in the same cycle)
//     pop, dout   retire the head; dout always shows the head slot
//     flush       empty the queue; overrides push and pop
//     full, empty occupancy flags
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DATA_W = $bits(fetch_entry_t),
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              do_push;
  logic              do_pop;

  // Self-protecting: a pop on empty is ignored, and a push on full is only
  // taken when the same-cycle pop frees the head slot.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction-fetch stage: owns the PC, addresses instruction memory,
//   queues returned words with their PC and hands them to decode over a
//   valid/ready handshake. A branch pulse flushes the queue and redirects.
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     imem_addr                  word address (pc >> 2), from the PC register only
//     imem_rd                    instruction word for imem_addr (combinational)
//     branch_valid/branch_target redirect pulse and byte target
//     inst_valid/inst/inst_pc    queue head presented to decode
//     inst_ready                 decode accepts the head
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          QUEUE_DEPTH = 2,
  parameter int          IMEM_AW     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rd,
  input  logic               branch_valid,
  input  logic [31:0]        branch_target,
  output logic               inst_valid,
  output logic [31:0]        inst,
  output logic [31:0]        inst_pc,
  input  logic               inst_ready
);

  logic [31:0]  pc;
  logic [31:0]  tgt_aligned;
  logic         pop;
  logic         push;
  logic         q_full;
  logic         q_empty;
  fetch_entry_t q_din;
  fetch_entry_t q_dout;

  assign tgt_aligned = branch_target & ~32'h0000_0003;

  // Address comes straight from the PC register, so decode's ready never
  // reaches memory combinationally. The cast zero-extends when IMEM_AW
  // exceeds the 30 meaningful word-address bits.
  assign imem_addr = IMEM_AW'(pc >> 2);

  assign inst_valid = ~q_empty;
  assign inst       = q_dout.instr;
  assign inst_pc    = q_dout.pc;

  // A branch squashes both sides of the handshake for this cycle.
  assign pop  = inst_valid & inst_ready;
  assign push = ~branch_valid & (~q_full | pop);

  assign q_din = '{pc: pc, instr: imem_rd};

  // ---- fetch stage: PC update ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (branch_valid) begin
      pc <= tgt_aligned;
    end else if (push) begin
      pc <= pc + PC_STEP;
    end
  end

  // ---- queue stage: fetched words wait here for decode ----
  fetch_queue #(
    .DATA_W ($bits(fetch_entry_t)),
    .DEPTH  (QUEUE_DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop & ~branch_valid),
    .flush (branch_valid),
    .din   (q_din),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  int checks;
  int errors;

  fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .QUEUE_DEPTH (2),
    .IMEM_AW     (32)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_rd       (imem_rd),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] M0 = 32'h00865007;
  localparam logic [31:0] M1 = 32'h01859123;
  localparam logic [31:0] M2 = 32'h01A018A2;
  localparam logic [31:0] M3 = 32'h07871001;
  localparam logic [31:0] M4 = 32'h32494832;

  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'd0:   return M0;
      32'd1:   return M1;
      32'd2:   return M2;
      32'd3:   return M3;
      32'd4:   return M4;
      default: return {a[15:0], 16'hA5A5};
    endcase
  endfunction

  assign imem_rd = memf(imem_addr);

  typedef struct {
    bit          rst_before;
    bit          ready;
    bit          br;
    logic [31:0] tgt;
    bit          ev;
    logic [31:0] einst;
    logic [31:0] epc;
    logic [31:0] eaddr;
    logic [31:0] ecnt;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after an edge with rst_n just released;
  // the next rising edge is the first one the design sees out of reset.
  task automatic do_reset();
    rst_n = 1'b0;
    branch_valid = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic drive(input bit rdy, input bit br, input logic [31:0] tgt);
    inst_ready    = rdy;
    branch_valid  = br;
    branch_target = tgt;
    #1;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    inst_ready    = 1'b0;
    branch_valid  = 1'b0;
    branch_target = '0;

    // {rst, ready, br, tgt, ev, inst, pc, addr, count}
    // Reset streaming
    vecs[0]  = '{1, 1, 0, 0, 0, 0,  0,     0, 0};
    vecs[1]  = '{0, 1, 0, 0, 1, M0, 32'h0, 1, 1};
    vecs[2]  = '{0, 1, 0, 0, 1, M1, 32'h4, 2, 1};
    vecs[3]  = '{0, 1, 0, 0, 1, M2, 32'h8, 3, 1};
    vecs[4]  = '{0, 1, 0, 0, 1, M3, 32'hC, 4, 1};
    // Stall from reset, then release (full with pop keeps count at 2)
    vecs[5]  = '{1, 0, 0, 0, 0, 0,  0,     0, 0};
    vecs[6]  = '{0, 0, 0, 0, 1, M0, 32'h0, 1, 1};
    vecs[7]  = '{0, 0, 0, 0, 1, M0, 32'h0, 2, 2};
    vecs[8]  = '{0, 0, 0, 0, 1, M0, 32'h0, 2, 2};
    vecs[9]  = '{0, 0, 0, 0, 1, M0, 32'h0, 2, 2};
    vecs[10] = '{0, 1, 0, 0, 1, M0, 32'h0, 2, 2};
    vecs[11] = '{0, 1, 0, 0, 1, M1, 32'h4, 3, 2};
    vecs[12] = '{0, 1, 0, 0, 1, M2, 32'h8, 4, 2};
    vecs[13] = '{0, 1, 0, 0, 1, M3, 32'hC, 5, 2};
    // Branch flush from a full queue to 0x13 (aligned to 0x10)
    vecs[14] = '{1, 0, 0, 0,        0, 0,  0,      0, 0};
    vecs[15] = '{0, 0, 0, 0,        1, M0, 32'h0,  1, 1};
    vecs[16] = '{0, 0, 1, 32'h13,   1, M0, 32'h0,  2, 2};
    vecs[17] = '{0, 0, 0, 0,        0, 0,  0,      4, 0};
    vecs[18] = '{0, 0, 0, 0,        1, M4, 32'h10, 5, 1};

    // Reset state while rst_n is held low
    rst_n = 1'b0;
    #2;
    chk("rst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);

    for (int i = 0; i < 19; i++) begin
      if (vecs[i].rst_before) do_reset();
      drive(vecs[i].ready, vecs[i].br, vecs[i].tgt);
      chk($sformatf("v%0d_valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].ev});
      chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].eaddr);
      chk($sformatf("v%0d_count", i), 32'(dut.u_queue.count), vecs[i].ecnt);
      if (vecs[i].ev) begin
        chk($sformatf("v%0d_inst", i), inst, vecs[i].einst);
        chk($sformatf("v%0d_pc", i), inst_pc, vecs[i].epc);
      end
      step();
    end

    // Simultaneous branch and pop: the pop is cancelled and the queue flushed
    do_reset();
    drive(1, 0, 0);
    step();
    drive(1, 1, 32'h8);
    chk("bp_head_valid", {31'b0, inst_valid}, 32'h1);
    chk("bp_head_pc", inst_pc, 32'h0);
    step();
    drive(1, 0, 0);
    chk("bp_empty", {31'b0, inst_valid}, 32'h0);
    chk("bp_count", 32'(dut.u_queue.count), 32'h0);
    chk("bp_pc", dut.pc, 32'h8);
    step();
    chk("bp_tgt_valid", {31'b0, inst_valid}, 32'h1);
    chk("bp_tgt_inst", inst, M2);
    chk("bp_tgt_pc", inst_pc, 32'h8);
    step();
    chk("bp_next_pc", inst_pc, 32'hC);

    // Asynchronous reset between edges while the queue is full
    do_reset();
    drive(0, 0, 0);
    step();
    step();
    chk("ar_full", 32'(dut.u_queue.count), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'b0, inst_valid}, 32'h0);
    chk("ar_pc", dut.pc, 32'h0);
    chk("ar_addr", imem_addr, 32'h0);
    chk("ar_inst", inst, 32'h0);
    chk("ar_inst_pc", inst_pc, 32'h0);

    // PC wrap: branch to the last word of the address space
    step();
    rst_n = 1'b1;
    drive(1, 1, 32'hFFFF_FFFC);
    step();
    drive(1, 0, 0);
    chk("wr_valid0", {31'b0, inst_valid}, 32'h0);
    chk("wr_addr0", imem_addr, 32'h3FFF_FFFF);
    step();
    chk("wr_inst1", inst, 32'hFFFF_A5A5);
    chk("wr_pc1", inst_pc, 32'hFFFF_FFFC);
    chk("wr_addr1", imem_addr, 32'h0);
    step();
    chk("wr_valid2", {31'b0, inst_valid}, 32'h1);
    chk("wr_inst2", inst, M0);
    chk("wr_pc2", inst_pc, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
